xc_pmul_unit: RTL and testbench

- Iterative packed unsigned multiplier in the execute stage; computes the rd value for xc.pmul.l / xc.pmul.h.
- The per-instruction formal spec models check its result on the retirement trace.
- Takes rs1/rs2 and a pack width from the decode/issue stage, performs one multiplier bit per cycle across all lanes, and returns the low or high halves of the per-lane products to writeback via a valid/ready response.

---
 rtl/xc_pkg.sv | 27 ++
 rtl/xc_pmul_lane_step.sv | 43 ++++
 rtl/xc_pmul_unit.sv | 122 ++++++++++++
 tb/tb_xc_pmul_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/xc_pkg.sv
// Shared definitions for the packed multiplier: pack-width encodings,
// lane-width lookup and the FSM state type.
package xc_pkg;

  localparam logic [1:0] PW_32 = 2'd0;
  localparam logic [1:0] PW_16 = 2'd1;
  localparam logic [1:0] PW_8  = 2'd2;
  localparam logic [1:0] PW_4  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [5:0] lane_width(input logic [1:0] pw);
    logic [5:0] w;
    case (pw)
      PW_32:   w = 6'd32;
      PW_16:   w = 6'd16;
      PW_8:    w = 6'd8;
      default: w = 6'd4;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/xc_pmul_lane_step.sv
// One shift-and-add multiplier step applied to every lane at once; each lane
// owns a 2w-bit slice of the 64-bit accumulator so carries never leave a lane.
module xc_pmul_lane_step
  import xc_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [63:0] mcand,
  input  logic [31:0] mplier,
  input  logic [1:0]  pw,
  output logic [63:0] acc_next,
  output logic [63:0] mcand_next,
  output logic [31:0] mplier_next
);

  logic [63:0] acc_w    [4];
  logic [63:0] mcand_w  [4];
  logic [31:0] mplier_w [4];

  // Index g of each array is the pack-width encoding; lane width is 32 >> g.
  for (genvar g = 0; g < 4; g++) begin : g_pw
    localparam int W = 32 >> g;
    localparam int L = 32 / W;
    logic [63:0] acc_l;
    logic [63:0] mcand_l;
    logic [31:0] mplier_l;

    for (genvar i = 0; i < L; i++) begin : g_lane
      assign acc_l[i*2*W +: 2*W]   = acc[i*2*W +: 2*W] +
                                     (mplier[i*W] ? mcand[i*2*W +: 2*W] : {(2*W){1'b0}});
      assign mcand_l[i*2*W +: 2*W] = mcand[i*2*W +: 2*W] << 1;
      assign mplier_l[i*W +: W]    = mplier[i*W +: W] >> 1;
    end

    assign acc_w[g]    = acc_l;
    assign mcand_w[g]  = mcand_l;
    assign mplier_w[g] = mplier_l;
  end

  assign acc_next    = acc_w[pw];
  assign mcand_next  = mcand_w[pw];
  assign mplier_next = mplier_w[pw];

endmodule

// File: rtl/xc_pmul_unit.sv
// Iterative packed unsigned multiplier for xc.pmul.l / xc.pmul.h: one multiplier
// bit per cycle across all lanes, result returned over a valid/ready handshake.
module xc_pmul_unit
  import xc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            g_clk,
  input  logic            g_rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_hi,
  input  logic [1:0]      req_pw,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result
);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q, mcand_q;
  logic [31:0] mplier_q;
  logic [1:0]  pw_q;
  logic        hi_q;
  logic [31:0] result_q;

  logic [63:0] acc_step, mcand_step;
  logic [31:0] mplier_step;
  logic [63:0] mcand_init;
  logic [31:0] result_asm;
  logic        accept;

  logic [63:0] mcand_init_w [4];
  logic [31:0] result_w     [4];

  xc_pmul_lane_step u_step (
    .acc         (acc_q),
    .mcand       (mcand_q),
    .mplier      (mplier_q),
    .pw          (pw_q),
    .acc_next    (acc_step),
    .mcand_next  (mcand_step),
    .mplier_next (mplier_step)
  );

  // Multiplicand lanes are zero-extended into 2w-bit slots; results take the
  // low or high half of each 2w-bit product slot.
  for (genvar g = 0; g < 4; g++) begin : g_pw
    localparam int W = 32 >> g;
    localparam int L = 32 / W;
    logic [63:0] mc_l;
    logic [31:0] res_l;

    for (genvar i = 0; i < L; i++) begin : g_lane
      assign mc_l[i*2*W +: 2*W] = {{W{1'b0}}, req_rs1[i*W +: W]};
      assign res_l[i*W +: W]    = hi_q ? acc_step[i*2*W + W +: W] : acc_step[i*2*W +: W];
    end

    assign mcand_init_w[g] = mc_l;
    assign result_w[g]     = res_l;
  end

  assign mcand_init = mcand_init_w[req_pw];
  assign result_asm = result_w[pw_q];
  assign accept     = (state_q == ST_IDLE) && req_valid && !flush;
  assign rsp_result = result_q;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == 6'd1) state_d = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      pw_q     <= PW_32;
      hi_q     <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q    <= 64'd0;
        mcand_q  <= mcand_init;
        mplier_q <= req_rs2;
        pw_q     <= req_pw;
        hi_q     <= req_hi;
        cnt_q    <= lane_width(req_pw);
      end else if (state_q == ST_RUN && !flush) begin
        acc_q    <= acc_step;
        mcand_q  <= mcand_step;
        mplier_q <= mplier_step;
        cnt_q    <= cnt_q - 6'd1;
        // Capture the result on the final step so it stays fixed throughout DONE.
        if (cnt_q == 6'd1) result_q <= result_asm;
      end
    end
  end

endmodule

// File: tb/tb_xc_pmul_unit.sv
// Directed self-checking bench for xc_pmul_unit: products, latency,
// backpressure, flush/reset aborts.
module tb_xc_pmul_unit;

  logic        g_clk = 1'b0;
  logic        g_rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_hi;
  logic [1:0]  req_pw;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;

  int total = 0;
  int bad   = 0;

  xc_pmul_unit #(.XLEN(32)) dut (
    .g_clk      (g_clk),
    .g_rst      (g_rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_hi     (req_hi),
    .req_pw     (req_pw),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result)
  );

  always #5 g_clk = ~g_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request at the negedge, let the next rising edge accept it,
  // then scramble the request inputs to show they are only sampled once.
  task automatic startOp(input logic [1:0] pw, input logic hi,
                         input logic [31:0] rs1, input logic [31:0] rs2);
    @(negedge g_clk);
    req_valid = 1'b1;
    req_pw    = pw;
    req_hi    = hi;
    req_rs1   = rs1;
    req_rs2   = rs2;
    checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
    req_rs1   = 32'hA5A5_5A5A;
    req_rs2   = 32'h5A5A_A5A5;
    req_pw    = ~pw;
    req_hi    = ~hi;
  endtask

  // Counts edges from the acceptance edge (counted as 1) to rsp_valid high.
  task automatic waitDone(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge g_clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseRsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge g_clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] pw, input logic hi,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] exp_res, input int exp_lat);
    int lat;
    startOp(pw, hi, rs1, rs2);
    waitDone(lat);
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_res"}, rsp_result, exp_res);
    releaseRsp(tag);
  endtask

  // Watches for any spurious rsp_valid over a window of cycles.
  task automatic expectQuiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge g_clk);
      #1;
      if (rsp_valid) seen++;
    end
    checkOutput(tag, seen, 0);
  endtask

  initial begin
    int          lat;
    logic [31:0] held;

    g_rst     = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_hi    = 1'b0;
    req_pw    = 2'd0;
    req_rs1   = 32'd0;
    req_rs2   = 32'd0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    g_rst = 1'b0;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_result", rsp_result, 32'd0);

    $display("[TB] directed products");
    applyStimulus("pw0_l", 2'd0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33);
    applyStimulus("pw0_h", 2'd0, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33);
    applyStimulus("pw0_ff_l", 2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    applyStimulus("pw0_ff_h", 2'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    applyStimulus("pw1_l", 2'd1, 1'b0, 32'hFFFF_0003, 32'hFFFF_0005, 32'h0001_000F, 17);
    applyStimulus("pw1_h", 2'd1, 1'b1, 32'hFFFF_0003, 32'hFFFF_0005, 32'hFFFE_0000, 17);
    applyStimulus("pw2_l", 2'd2, 1'b0, 32'h8020_3040, 32'h0202_0202, 32'h0040_6080, 9);
    applyStimulus("pw2_h", 2'd2, 1'b1, 32'h8020_3040, 32'h0202_0202, 32'h0100_0000, 9);
    applyStimulus("pw2_ff_l", 2'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0101_0101, 9);
    applyStimulus("pw2_ff_h", 2'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFEFE_FEFE, 9);
    applyStimulus("pw3_l", 2'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1111_1111, 5);
    applyStimulus("pw3_h", 2'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hEEEE_EEEE, 5);

    $display("[TB] backpressure");
    startOp(2'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(lat);
    checkOutput("bp_lat", lat, 5);
    held = rsp_result;
    checkOutput("bp_res", held, 32'hEEEE_EEEE);
    for (int i = 0; i < 3; i++) begin
      @(posedge g_clk);
      #1;
      checkOutput("bp_valid_hold", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_res_hold", rsp_result, 32'hEEEE_EEEE);
      checkOutput("bp_not_ready", {31'd0, req_ready}, 32'd0);
    end
    releaseRsp("bp");

    $display("[TB] flush abort");
    startOp(2'd0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge g_clk);
    #1;
    flush = 1'b1;
    @(posedge g_clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_idle", {31'd0, req_ready}, 32'd1);
    checkOutput("flush_no_valid", {31'd0, rsp_valid}, 32'd0);
    expectQuiet("flush_quiet", 40);
    applyStimulus("post_flush", 2'd1, 1'b0, 32'hFFFF_0003, 32'hFFFF_0005, 32'h0001_000F, 17);

    $display("[TB] reset abort");
    startOp(2'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (12) @(posedge g_clk);
    #1;
    g_rst = 1'b1;
    @(posedge g_clk);
    #1;
    g_rst = 1'b0;
    checkOutput("rst_mid_idle", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_mid_no_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_mid_result", rsp_result, 32'd0);
    expectQuiet("rst_quiet", 40);
    applyStimulus("post_rst", 2'd1, 1'b0, 32'hFFFF_0003, 32'hFFFF_0005, 32'h0001_000F, 17);

    $display("[TB] flush with request");
    @(negedge g_clk);
    req_valid = 1'b1;
    req_pw    = 2'd3;
    req_hi    = 1'b0;
    req_rs1   = 32'hFFFF_FFFF;
    req_rs2   = 32'hFFFF_FFFF;
    flush     = 1'b1;
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    checkOutput("flush_req_idle", {31'd0, req_ready}, 32'd1);
    expectQuiet("flush_req_quiet", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
